// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start, 8 data bits LSB first, optional parity, stop.
// Optional break detection output is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_deframer #(
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_POINT = OVERSAMPLE / 2 - 1
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       BaudTick,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       ParityError,
  output logic       FramingError,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic       BreakDetected,
`endif
  output logic       Busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [1:0]       ptype_q;
  logic             par_err_q;
  logic             par_bit_q;
  logic             at_sample;
  logic             at_last;
  logic             parity_en;
  logic             par_expected;

  always_comb begin
    tick_cnt_d   = (tick_cnt_q == LAST_CNT) ? '0 : tick_cnt_q + 1'b1;
    at_sample    = (tick_cnt_q == SAMPLE_CNT);
    at_last      = (tick_cnt_q == LAST_CNT);
    parity_en    = ptype_q[0] ^ ptype_q[1];
    par_expected = ptype_q[0] ? ~^shift_q : ^shift_q;
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic break_now;
  assign break_now = (shift_q == 8'h00) && !rx_sync_q && (!parity_en || !par_bit_q);
`endif

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptype_q      <= '0;
      par_err_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      DataOut      <= '0;
      DataValid    <= 1'b0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
      Busy         <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      BreakDetected <= 1'b0;
`endif
    end else begin
      rx_meta_q <= RxIn;
      rx_sync_q <= rx_meta_q;
      DataValid <= 1'b0;
      if (BaudTick) begin
        // Counting from the detected edge puts SAMPLE_POINT mid-bit for every later bit.
        tick_cnt_q <= (state_q == S_IDLE) ? '0 : tick_cnt_d;
        case (state_q)
          S_IDLE: begin
            if (!rx_sync_q) begin
              state_q      <= S_START;
              ptype_q      <= ParityType;
              Busy         <= 1'b1;
              ParityError  <= 1'b0;
              FramingError <= 1'b0;
              par_err_q    <= 1'b0;
              par_bit_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
              BreakDetected <= 1'b0;
`endif
            end
          end
          S_START: begin
            if (at_sample && rx_sync_q) begin
              state_q <= S_IDLE;
              Busy    <= 1'b0;
            end else if (at_last) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            if (at_sample) begin
              shift_q <= {rx_sync_q, shift_q[7:1]};
            end
            if (at_last) begin
              if (bit_cnt_q == 3'd7) begin
                state_q <= parity_en ? S_PARITY : S_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          S_PARITY: begin
            if (at_sample) begin
              par_bit_q <= rx_sync_q;
              par_err_q <= (rx_sync_q != par_expected);
            end
            if (at_last) begin
              state_q <= S_STOP;
            end
          end
          S_STOP: begin
            if (at_sample) begin
              DataOut      <= shift_q;
              DataValid    <= 1'b1;
              ParityError  <= par_err_q;
              FramingError <= !rx_sync_q;
`ifdef UART_RX_BREAK_DETECT_EN
              BreakDetected <= break_now;
`endif
              if (rx_sync_q) begin
                state_q <= S_IDLE;
                Busy    <= 1'b0;
              end else begin
                state_q <= S_WAIT_HIGH;
              end
            end
          end
          S_WAIT_HIGH: begin
            if (rx_sync_q) begin
              state_q <= S_IDLE;
              Busy    <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            Busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
